// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Shared scheduler state encoding and the round-robin pick helper.
// Rev    : 1.0  initial release
// ============================================================================
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4
  } sched_state_t;

  // With both sources pending the one not served last wins.
  function automatic logic rr_pick(input logic last, input logic [1:0] nempty);
    if (&nempty) return ~last;
    return nempty[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module : uart_byte_fifo
// Small synchronous FIFO; full/empty come from the registered occupancy count.
// Rev    : 1.0  initial release
// ============================================================================
module uart_byte_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cw = $clog2(DEPTH) + 1;
  localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);
  localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);
  localparam logic [c_cw-1:0] c_cnt_max = c_cw'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_cw-1:0]   r_count;
  logic              w_push;
  logic              w_pop;

  assign full   = (r_count == c_cnt_max);
  assign empty  = (r_count == '0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign head   = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone defines valid entries.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_scheduler
// Round-robin sharing of one UART transmitter between two buffered byte sources.
// Rev    : 1.0  initial release
// ============================================================================
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int DATA_W      = UART_DATA_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid_i,
  input  logic [2*DATA_W-1:0] req_data_i,
  output logic [1:0]          req_ready_o,
  output logic [DATA_W-1:0]   tx_data_o,
  output logic                tx_start_o,
  input  logic                tx_busy_i,
  output logic [1:0]          grant_o,
  output logic                busy_o,
  output logic                err_timeout_o,
  input  logic                err_clr_i,
  output logic [CNT_W-1:0]    sent_cnt_o
);

  localparam int c_ack_w = $clog2(ACK_TIMEOUT + 1);
  localparam logic [c_ack_w-1:0] c_ack_last = c_ack_w'(ACK_TIMEOUT - 1);
  localparam logic [c_ack_w-1:0] c_ack_one  = c_ack_w'(1);
  localparam logic [CNT_W-1:0]   c_cnt_one  = CNT_W'(1);

  sched_state_t        r_state;
  logic                r_last;
  logic [c_ack_w-1:0]  r_ack_cnt;
  logic [DATA_W-1:0]   r_tx_data;
  logic                r_tx_start;
  logic [1:0]          r_grant;
  logic                r_err;
  logic [CNT_W-1:0]    r_sent_cnt;

  logic [1:0]          w_full;
  logic [1:0]          w_empty;
  logic [1:0]          w_nempty;
  logic [1:0]          w_pop;
  logic [DATA_W-1:0]   w_head [2];
  logic                w_pick;
  logic                w_grant_en;
  logic                w_ack_expire;

  generate
    for (genvar n = 0; n < 2; n++) begin : g_fifo
      uart_byte_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
      ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_valid_i[n]),
        .push_data (req_data_i[n*DATA_W +: DATA_W]),
        .pop       (w_pop[n]),
        .head      (w_head[n]),
        .full      (w_full[n]),
        .empty     (w_empty[n])
      );
    end
  endgenerate

  assign req_ready_o = ~w_full;
  assign w_nempty    = ~w_empty;
  assign w_pick      = rr_pick(r_last, w_nempty);
  // A foreign frame on the line (busy while idle) holds off new grants.
  assign w_grant_en  = (r_state == IDLE) && !tx_busy_i && (|w_nempty);
  assign w_ack_expire = (r_state == WAIT_ACK) && !tx_busy_i && (r_ack_cnt == c_ack_last);

  always_comb begin
    w_pop = 2'b00;
    if (w_grant_en) w_pop[w_pick] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_ack_cnt  <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_grant    <= 2'b00;
      r_err      <= 1'b0;
      r_sent_cnt <= '0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_en) begin
            r_tx_data <= w_head[w_pick];
            r_grant   <= w_pick ? 2'b10 : 2'b01;
            r_state   <= LOAD;
          end
        end
        LOAD: begin
          r_tx_start <= 1'b1;
          r_state    <= START;
        end
        START: begin
          r_ack_cnt <= '0;
          r_state   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (tx_busy_i) begin
            r_state <= WAIT_DONE;
          end else if (w_ack_expire) begin
            r_grant <= 2'b00;
            r_state <= IDLE;
          end else begin
            r_ack_cnt <= r_ack_cnt + c_ack_one;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy_i) begin
            r_sent_cnt <= r_sent_cnt + c_cnt_one;
            r_last     <= r_grant[1];
            r_grant    <= 2'b00;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
      // A timeout raised in the same cycle as a clear keeps the flag set.
      if (w_ack_expire)   r_err <= 1'b1;
      else if (err_clr_i) r_err <= 1'b0;
    end
  end

  assign tx_data_o     = r_tx_data;
  assign tx_start_o    = r_tx_start;
  assign grant_o       = r_grant;
  assign busy_o        = (r_state != IDLE);
  assign err_timeout_o = r_err;
  assign sent_cnt_o    = r_sent_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx_scheduler
// Scoreboard bench for uart_tx_scheduler with a stub transmitter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_tx_scheduler;

  localparam int AT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid_i = 2'b00;
  logic [15:0] req_data_i = '0;
  logic [1:0]  req_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_start_o;
  logic        tx_busy_i;
  logic [1:0]  grant_o;
  logic        busy_o;
  logic        err_timeout_o;
  logic        err_clr_i = 1'b0;
  logic [3:0]  sent_cnt_o;

  typedef struct {
    logic [7:0] data;
    logic [1:0] grant;
  } exp_t;
  exp_t q[$];

  int vectors = 0;
  int miscompares = 0;

  logic hold_busy = 1'b0;
  logic stub_en = 1'b1;
  logic stub_busy = 1'b0;
  int   stub_dly = 0;
  int   stub_len = 0;

  assign tx_busy_i = stub_busy | hold_busy;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .DATA_W(8), .FIFO_DEPTH(4), .ACK_TIMEOUT(AT), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .tx_data_o(tx_data_o), .tx_start_o(tx_start_o),
    .tx_busy_i(tx_busy_i), .grant_o(grant_o), .busy_o(busy_o),
    .err_timeout_o(err_timeout_o), .err_clr_i(err_clr_i), .sent_cnt_o(sent_cnt_o)
  );

  // Stub transmitter: busy from two cycles after start, for ten cycles.
  always @(posedge clk) begin
    if (stub_dly != 0) begin
      stub_dly <= stub_dly - 1;
      if (stub_dly == 1) begin
        stub_busy <= 1'b1;
        stub_len  <= 10;
      end
    end else if (stub_len != 0) begin
      stub_len <= stub_len - 1;
      if (stub_len == 1) stub_busy <= 1'b0;
    end
    if (tx_start_o && stub_en) stub_dly <= 1;
  end

  // Scoreboard: every start pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && tx_start_o) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_start: data=%h grant=%b, no byte expected", tx_data_o, grant_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (tx_data_o !== e.data || grant_o !== e.grant) begin
          miscompares++;
          $display("FAIL tx_byte: got data=%h grant=%b, want data=%h grant=%b",
                   tx_data_o, grant_o, e.data, e.grant);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    req_valid_i = 2'b00;
    err_clr_i = 1'b0;
    hold_busy = 1'b0;
    stub_en = 1'b1;
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input bit track);
    int n = 0;
    bit done = 0;
    req_valid_i[r] = 1'b1;
    req_data_i[r*8 +: 8] = d;
    while (!done && n < 2000) begin
      @(negedge clk);
      if (req_ready_o[r]) done = 1;
      @(posedge clk);
      #1;
      n++;
    end
    req_valid_i[r] = 1'b0;
    if (done && track) q.push_back('{data: d, grant: (r == 1) ? 2'b10 : 2'b01});
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL push_wait: req%0d never ready, ready=%b want 1", r, req_ready_o);
    end
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while ((q.size() != 0 || busy_o || tx_busy_i) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= maxc) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d bytes pending busy_o=%b, want 0 pending", q.size(), busy_o);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors++;
    if ({tx_data_o, tx_start_o, grant_o, busy_o, err_timeout_o, sent_cnt_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: data=%h start=%b grant=%b busy=%b err=%b cnt=%0d, want all 0",
               tx_data_o, tx_start_o, grant_o, busy_o, err_timeout_o, sent_cnt_o);
    end
    vectors++;
    if (req_ready_o !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 11", req_ready_o);
    end
  endtask

  task automatic test_single();
    do_reset();
    @(posedge clk);
    #1;
    req_valid_i[0] = 1'b1;
    req_data_i[7:0] = 8'hA5;
    q.push_back('{data: 8'hA5, grant: 2'b01});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (tx_start_o !== (i == 3)) begin
        miscompares++;
        $display("FAIL start_latency: cycle t+%0d start=%b want %b", i, tx_start_o, (i == 3));
      end
      if (i == 0) begin
        @(posedge clk);
        #1 req_valid_i[0] = 1'b0;
      end
    end
    wait_drain(100);
    vectors++;
    if (sent_cnt_o !== 4'd1 || tx_data_o !== 8'hA5 || grant_o !== 2'b00) begin
      miscompares++;
      $display("FAIL single_done: cnt=%0d data=%h grant=%b want 1 a5 00", sent_cnt_o, tx_data_o, grant_o);
    end
  endtask

  task automatic test_contention();
    do_reset();
    hold_busy = 1'b1;
    push_byte(0, 8'h11, 0);
    push_byte(0, 8'h12, 0);
    push_byte(1, 8'h21, 0);
    push_byte(1, 8'h22, 0);
    q.push_back('{data: 8'h11, grant: 2'b01});
    q.push_back('{data: 8'h21, grant: 2'b10});
    q.push_back('{data: 8'h12, grant: 2'b01});
    q.push_back('{data: 8'h22, grant: 2'b10});
    @(negedge clk);
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL foreign_busy_blocks: busy_o=%b want 0", busy_o);
    end
    hold_busy = 1'b0;
    wait_drain(300);
    vectors++;
    if (sent_cnt_o !== 4'd4) begin
      miscompares++;
      $display("FAIL contention_count: got %0d want 4", sent_cnt_o);
    end
  endtask

  task automatic test_full();
    do_reset();
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) push_byte(1, 8'h60 + 8'(i), 1);
    @(negedge clk);
    vectors++;
    if (req_ready_o !== 2'b01) begin
      miscompares++;
      $display("FAIL full_ready: got %b want 01", req_ready_o);
    end
    req_valid_i[1] = 1'b1;
    req_data_i[15:8] = 8'h6F;
    @(posedge clk);
    #1 req_valid_i[1] = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready_o[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL full_hold: ready1=%b want 0", req_ready_o[1]);
    end
    hold_busy = 1'b0;
    wait_drain(300);
    vectors++;
    if (sent_cnt_o !== 4'd4) begin
      miscompares++;
      $display("FAIL full_count: got %0d want 4", sent_cnt_o);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    stub_en = 1'b0;
    push_byte(0, 8'h3C, 1);
    while (!tx_start_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!tx_start_o) begin
      miscompares++;
      $display("FAIL timeout_start: start=%b want 1", tx_start_o);
    end
    for (int i = 1; i <= AT + 1; i++) begin
      @(negedge clk);
      if (i == AT) begin
        vectors++;
        if (err_timeout_o !== 1'b0 || busy_o !== 1'b1) begin
          miscompares++;
          $display("FAIL timeout_early: err=%b busy=%b want 0 1", err_timeout_o, busy_o);
        end
      end
      if (i == AT + 1) begin
        vectors++;
        if (err_timeout_o !== 1'b1 || busy_o !== 1'b0 || grant_o !== 2'b00 || sent_cnt_o !== 4'd0) begin
          miscompares++;
          $display("FAIL timeout_abort: err=%b busy=%b grant=%b cnt=%0d want 1 0 00 0",
                   err_timeout_o, busy_o, grant_o, sent_cnt_o);
        end
      end
    end
    stub_en = 1'b1;
    push_byte(0, 8'h3D, 1);
    wait_drain(100);
    vectors++;
    if (sent_cnt_o !== 4'd1 || err_timeout_o !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_next: cnt=%0d err=%b want 1 1", sent_cnt_o, err_timeout_o);
    end
    @(posedge clk);
    #1 err_clr_i = 1'b1;
    @(posedge clk);
    #1 err_clr_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (err_timeout_o !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear: err=%b want 0", err_timeout_o);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int starts = 0;
    do_reset();
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) push_byte(0, 8'h70 + 8'(i), 1);
    hold_busy = 1'b0;
    while (!stub_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (busy_o !== 1'b1 || tx_busy_i !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_frame: busy_o=%b tx_busy=%b want 1 1", busy_o, tx_busy_i);
    end
    #2 rst = 1'b1;
    #1;
    q.delete();
    vectors++;
    if ({tx_data_o, tx_start_o, grant_o, busy_o, err_timeout_o, sent_cnt_o} !== '0 ||
        req_ready_o !== 2'b11) begin
      miscompares++;
      $display("FAIL async_reset: data=%h start=%b grant=%b busy=%b cnt=%0d ready=%b want 0s ready 11",
               tx_data_o, tx_start_o, grant_o, busy_o, sent_cnt_o, req_ready_o);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_start_o) starts++;
    end
    vectors++;
    if (starts != 0) begin
      miscompares++;
      $display("FAIL post_reset_start: got %0d starts want 0", starts);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) push_byte(0, 8'(i) ^ 8'h5A, 1);
    wait_drain(2000);
    vectors++;
    if (sent_cnt_o !== 4'd1) begin
      miscompares++;
      $display("FAIL count_wrap: got %0d want 1", sent_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
